// File: rtl/player_motion_ctrl_if.sv
// rtl/player_motion_ctrl_if.sv - raster, button and sprite-position signals of player_motion_ctrl
interface player_motion_ctrl_if;
    logic       enable;
    logic [9:0] v_counter;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [7:0] player_x_pos;
    logic [7:0] player_y_pos;
    logic       frame_tick;
    logic       busy;

    modport slave (
        input  enable, v_counter, btn_up, btn_down, btn_left, btn_right,
        output player_x_pos, player_y_pos, frame_tick, busy
    );

    modport master (
        output enable, v_counter, btn_up, btn_down, btn_left, btn_right,
        input  player_x_pos, player_y_pos, frame_tick, busy
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - once-per-frame sprite position update from four buttons
// Position is only committed in COMMIT, so the pixel generator never sees a mid-frame move.
module player_motion_ctrl #(
    parameter int STEP        = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 235,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 235,
    parameter int X_INIT      = 118,
    parameter int Y_INIT      = 118,
    parameter int UPDATE_LINE = 599
) (
    input  logic                  clk,
    input  logic                  reset,
    player_motion_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic signed [9:0] STEP_S  = 10'(STEP);
    localparam logic signed [9:0] X_MIN_S = 10'(X_MIN);
    localparam logic signed [9:0] X_MAX_S = 10'(X_MAX);
    localparam logic signed [9:0] Y_MIN_S = 10'(Y_MIN);
    localparam logic signed [9:0] Y_MAX_S = 10'(Y_MAX);
    localparam logic [9:0]        LINE    = 10'(UPDATE_LINE);

    state_t     state;
    state_t     state_next;

    // button vectors are ordered {up, down, left, right}
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;
    logic [3:0] btn_lat;
    logic [9:0] v_prev;
    logic       trig;

    logic       latch_btn;
    logic       do_x;
    logic       do_y;
    logic       do_commit;

    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic [7:0] nx;
    logic [7:0] ny;
    logic       tick;

    function automatic logic [7:0] step_clamp(
        input logic [7:0]        pos,
        input logic              inc,
        input logic              dec,
        input logic signed [9:0] lo,
        input logic signed [9:0] hi
    );
        logic signed [9:0] v;
        v = signed'({2'b00, pos});
        if (inc && !dec)
            v = v + STEP_S;
        else if (dec && !inc)
            v = v - STEP_S;
        if (v < lo)
            v = lo;
        else if (v > hi)
            v = hi;
        return v[7:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 4'b0;
            btn_sync <= 4'b0;
            v_prev   <= 10'd0;
        end else begin
            btn_meta <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
            btn_sync <= btn_meta;
            v_prev   <= bus.v_counter;
        end
    end

    // Edge detect on the raster line: one trigger however long v_counter dwells there.
    assign trig = bus.enable && (bus.v_counter == LINE) && (v_prev != LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trig) state_next = CALC_X;
            CALC_X:  state_next = CALC_Y;
            CALC_Y:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        latch_btn = 1'b0;
        do_x      = 1'b0;
        do_y      = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE:    latch_btn = trig;
            CALC_X:  do_x      = 1'b1;
            CALC_Y:  do_y      = 1'b1;
            COMMIT:  do_commit = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_lat <= 4'b0;
            nx      <= 8'(X_INIT);
            ny      <= 8'(Y_INIT);
            x_pos   <= 8'(X_INIT);
            y_pos   <= 8'(Y_INIT);
            tick    <= 1'b0;
        end else begin
            tick <= do_commit;
            if (latch_btn)
                btn_lat <= btn_sync;
            if (do_x)
                nx <= step_clamp(x_pos, btn_lat[0], btn_lat[1], X_MIN_S, X_MAX_S);
            if (do_y)
                ny <= step_clamp(y_pos, btn_lat[2], btn_lat[3], Y_MIN_S, Y_MAX_S);
            if (do_commit) begin
                x_pos <= nx;
                y_pos <= ny;
            end
        end
    end

    assign bus.player_x_pos = x_pos;
    assign bus.player_y_pos = y_pos;
    assign bus.frame_tick   = tick;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - self-checking bench for player_motion_ctrl
module tb_player_motion_ctrl;

    logic clk;
    logic reset;
    player_motion_ctrl_if bus ();

    player_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_x = 118;
    int exp_y = 118;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int move(input int pos, input bit inc, input bit dec, input int lo, input int hi);
        int v;
        v = pos + ((inc && !dec) ? 2 : 0) - ((dec && !inc) ? 2 : 0);
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v;
    endfunction

    task automatic check_out(input string tag, input int x, input int y, input bit tk, input bit bz);
        check({tag, ".x"},    32'(bus.player_x_pos), 32'(x));
        check({tag, ".y"},    32'(bus.player_y_pos), 32'(y));
        check({tag, ".tick"}, 32'(bus.frame_tick),   32'(tk));
        check({tag, ".busy"}, 32'(bus.busy),         32'(bz));
    endtask

    // One frame: buttons settle, raster steps 598 -> 599 (held 4 clk), outputs followed edge by edge.
    task automatic frame(input string tag, input bit u, input bit d, input bit l, input bit r,
                         input bit en, input bit drop_en, input bit tog_down);
        int nx;
        int ny;
        @(negedge clk);
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
        bus.enable = en;
        bus.v_counter = 10'd598;
        repeat (4) @(negedge clk);
        nx = en ? move(exp_x, r, l, 0, 235) : exp_x;
        ny = en ? move(exp_y, d, u, 0, 235) : exp_y;
        bus.v_counter = 10'd599;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("%s.e%0d", tag, i),
                      (en && i >= 3) ? nx : exp_x,
                      (en && i >= 3) ? ny : exp_y,
                      en && (i == 3),
                      en && (i < 3));
            if (i == 0 && drop_en) bus.enable = 1'b0;
            if (tog_down && (i == 1 || i == 2)) bus.btn_down = ~bus.btn_down;
            if (i == 3) bus.v_counter = 10'd0;
        end
        exp_x = nx;
        exp_y = ny;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.v_counter = 10'd0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 118, 118, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_out("post_reset", 118, 118, 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) frame("right", 0, 0, 0, 1, 1, 0, 0);

        // reset while the FSM sits in CALC_Y
        @(negedge clk);
        bus.btn_right = 1'b1; bus.enable = 1'b1; bus.v_counter = 10'd598;
        repeat (4) @(negedge clk);
        bus.v_counter = 10'd599;
        @(negedge clk);
        check("midreset.busy_calc_x", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.v_counter = 10'd0;
        #1;
        check_out("midreset.async", 118, 118, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_x = 118;
        exp_y = 118;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("midreset.after%0d", i), 118, 118, 1'b0, 1'b0);
        end

        for (int f = 0; f < 2; f++) frame("lr_up", 1, 0, 1, 1, 1, 0, 0);
        for (int f = 0; f < 3; f++) frame("disabled", 0, 1, 0, 1, 0, 0, 0);
        frame("down_toggle", 0, 0, 0, 0, 1, 0, 1);
        frame("drop_enable", 0, 0, 0, 1, 1, 1, 0);
        frame("after_drop", 0, 0, 0, 1, 0, 0, 0);

        while (exp_x < 234) frame("to_234", 0, 0, 0, 1, 1, 0, 0);
        check("at_234", 32'(bus.player_x_pos), 32'd234);
        frame("clamp_hi1", 0, 0, 0, 1, 1, 0, 0);
        frame("clamp_hi2", 0, 0, 0, 1, 1, 0, 0);
        check("clamp_hi", 32'(bus.player_x_pos), 32'd235);
        while (exp_x > 1) frame("to_1", 0, 0, 1, 0, 1, 0, 0);
        check("at_1", 32'(bus.player_x_pos), 32'd1);
        frame("clamp_lo", 0, 0, 1, 0, 1, 0, 0);
        check("clamp_lo", 32'(bus.player_x_pos), 32'd0);

        for (int f = 0; f < 24; f++) begin
            frame("random",
                  1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                  ($urandom % 4) != 0, ($urandom % 4) == 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
